clock_display_driver: RTL and testbench

CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

---
 rtl/clock_display_driver_if.sv | 26 ++
 rtl/clock_display_driver.sv | 127 ++++++++++++
 tb/tb_clock_display_driver.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_display_driver_if.sv
// Digit snapshot inputs and multiplexed 7-segment outputs for the clock display driver.
// The master side is the clock core; the slave side is the display driver.
interface clock_display_driver_if;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic [3:0] S_in1;
    logic [3:0] S_in0;
    logic       load;
    logic       Alarm;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       digit_err;

    modport master (
        output H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, load, Alarm,
        input  seg, an, dp, digit_err
    );

    modport slave (
        input  H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, load, Alarm,
        output seg, an, dp, digit_err
    );
endinterface

// File: rtl/clock_display_driver.sv
// Six-digit multiplexed 7-segment driver for an HH:MM:SS clock with shadow
// snapshot registers, digit validation, blinking colon and alarm flashing.
module clock_display_driver #(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned BLINK_DIV = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    clock_display_driver_if.slave bus
);
    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IDX_W   = 3;
    localparam logic [6:0]  SEG_DASH  = 7'h40;
    localparam logic [6:0]  SEG_BLANK = 7'h00;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               blink_phase_q, blink_phase_d;
    logic               digit_err_q, digit_err_d;
    logic [1:0]         h1_q;
    logic [3:0]         h0_q, m1_q, m0_q, s1_q, s0_q;
    logic               scan_wrap_c, blink_wrap_c, in_err_c;
    logic [3:0]         digit_c;
    logic               digit_bad_c, lead_blank_c, flash_off_c;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'h3F;
            4'd1:    bcd_to_seg = 7'h06;
            4'd2:    bcd_to_seg = 7'h5B;
            4'd3:    bcd_to_seg = 7'h4F;
            4'd4:    bcd_to_seg = 7'h66;
            4'd5:    bcd_to_seg = 7'h6D;
            4'd6:    bcd_to_seg = 7'h7D;
            4'd7:    bcd_to_seg = 7'h07;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h6F;
            default: bcd_to_seg = SEG_DASH;
        endcase
    endfunction

    // Scan/blink dividers and the load-time validity check of the incoming snapshot
    always_comb begin
        scan_wrap_c   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        blink_wrap_c  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        scan_cnt_d    = scan_wrap_c ? '0 : scan_cnt_q + SCAN_W'(1);
        blink_cnt_d   = blink_wrap_c ? '0 : blink_cnt_q + BLINK_W'(1);
        idx_d         = idx_q;
        if (scan_wrap_c) begin
            idx_d = (idx_q == IDX_W'(5)) ? '0 : idx_q + IDX_W'(1);
        end
        blink_phase_d = blink_wrap_c ? ~blink_phase_q : blink_phase_q;
        in_err_c      = (bus.S_in0 > 4'd9) | (bus.S_in1 > 4'd5) |
                        (bus.M_in0 > 4'd9) | (bus.M_in1 > 4'd5) |
                        (bus.H_in0 > 4'd9) | (bus.H_in1 > 2'd2) |
                        ((bus.H_in1 == 2'd2) && (bus.H_in0 > 4'd3));
        digit_err_d   = bus.load ? in_err_c : digit_err_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            idx_q         <= '0;
            blink_phase_q <= 1'b1;
            digit_err_q   <= 1'b0;
            h1_q          <= '0;
            h0_q          <= '0;
            m1_q          <= '0;
            m0_q          <= '0;
            s1_q          <= '0;
            s0_q          <= '0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            idx_q         <= idx_d;
            blink_phase_q <= blink_phase_d;
            digit_err_q   <= digit_err_d;
            if (bus.load) begin
                h1_q <= bus.H_in1;
                h0_q <= bus.H_in0;
                m1_q <= bus.M_in1;
                m0_q <= bus.M_in0;
                s1_q <= bus.S_in1;
                s0_q <= bus.S_in0;
            end
        end
    end

    // Zero-latency decode of the scanned shadow digit; an out-of-range 2x hour dashes the units digit
    always_comb begin
        digit_c      = s0_q;
        digit_bad_c  = 1'b0;
        lead_blank_c = 1'b0;
        case (idx_q)
            3'd0: begin digit_c = s0_q; digit_bad_c = (s0_q > 4'd9); end
            3'd1: begin digit_c = s1_q; digit_bad_c = (s1_q > 4'd5); end
            3'd2: begin digit_c = m0_q; digit_bad_c = (m0_q > 4'd9); end
            3'd3: begin digit_c = m1_q; digit_bad_c = (m1_q > 4'd5); end
            3'd4: begin
                digit_c     = h0_q;
                digit_bad_c = (h0_q > 4'd9) || ((h1_q == 2'd2) && (h0_q > 4'd3));
            end
            3'd5: begin
                digit_c      = {2'b00, h1_q};
                digit_bad_c  = (h1_q > 2'd2);
                lead_blank_c = (h1_q == 2'd0);
            end
            default: ;
        endcase
        flash_off_c = bus.Alarm & ~blink_phase_q;

        bus.an  = 6'b000001 << idx_q;
        bus.seg = digit_bad_c  ? SEG_DASH :
                  lead_blank_c ? SEG_BLANK : bcd_to_seg(digit_c);
        bus.dp  = blink_phase_q && ((idx_q == IDX_W'(2)) || (idx_q == IDX_W'(4)));
        if (flash_off_c) begin
            bus.an  = '0;
            bus.seg = SEG_BLANK;
            bus.dp  = 1'b0;
        end
    end

    assign bus.digit_err = digit_err_q;
endmodule

// File: tb/tb_clock_display_driver.sv
// Scoreboard bench for clock_display_driver: expectations are queued with the
// edge count at which they must appear and compared as the scan reaches them.
module tb_clock_display_driver;
    logic clock = 1'b0;
    logic reset;
    int unsigned t;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int unsigned at;
        logic [5:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    clock_display_driver_if bus();

    clock_display_driver #(.SCAN_DIV(4), .BLINK_DIV(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Rising edges since reset release
    always @(posedge clock or posedge reset) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    function automatic void push(string n, int unsigned at, logic [5:0] an,
                                 logic [6:0] seg, logic dp, logic err);
        exp_t e;
        e.name = n; e.at = at; e.an = an; e.seg = seg; e.dp = dp; e.err = err;
        sb.push_back(e);
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.load = 1'b0;
        bus.Alarm = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                           input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        bus.H_in1 = h1; bus.H_in0 = h0; bus.M_in1 = m1;
        bus.M_in0 = m0; bus.S_in1 = s1; bus.S_in0 = s0;
        bus.load = 1'b1;
        @(posedge clock);
        #1 bus.load = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        exp_t e;
        int n = 0;
        repeat (2) @(negedge clock);
        push("reset_held", 0, 6'b000001, 7'h3F, 1'b0, 1'b0);
        forever begin
            #1;
            while (sb.size() != 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                    failures++;
                    $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                             e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                end
            end
            if (sb.size() == 0) break;
            n++;
            if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
            @(negedge clock);
        end
        reset = 1'b0;
        push("post_reset_t0", 0, 6'b000001, 7'h3F, 1'b0, 1'b0);
        push("post_reset_t3", 3, 6'b000001, 7'h3F, 1'b0, 1'b0);
        push("post_reset_t4", 4, 6'b000010, 7'h3F, 1'b0, 1'b0);
        push("post_reset_t8", 8, 6'b000100, 7'h3F, 1'b1, 1'b0);
        n = 0;
        forever begin
            #1;
            while (sb.size() != 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                    failures++;
                    $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                             e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                end
            end
            if (sb.size() == 0) break;
            n++;
            if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
            @(negedge clock);
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int n = 0;
        apply_reset();
        do_load(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        push("scan_idx0",  1,  6'b000001, 7'h7D, 1'b0, 1'b0);
        push("scan_idx1",  4,  6'b000010, 7'h6D, 1'b0, 1'b0);
        push("scan_idx2",  8,  6'b000100, 7'h66, 1'b1, 1'b0);
        push("scan_idx3",  12, 6'b001000, 7'h4F, 1'b0, 1'b0);
        push("scan_idx4",  16, 6'b010000, 7'h5B, 1'b0, 1'b0);
        push("scan_idx5",  20, 6'b100000, 7'h06, 1'b0, 1'b0);
        push("scan_last5", 23, 6'b100000, 7'h06, 1'b0, 1'b0);
        push("scan_wrap0", 24, 6'b000001, 7'h7D, 1'b0, 1'b0);
        forever begin
            #1;
            while (sb.size() != 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                    failures++;
                    $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                             e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                end
            end
            if (sb.size() == 0) break;
            n++;
            if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
            @(negedge clock);
        end
    endtask

    task automatic test_leading_blank();
        exp_t e;
        int n = 0;
        apply_reset();
        do_load(2'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'd0);
        push("lz_idx0", 1,  6'b000001, 7'h3F, 1'b0, 1'b0);
        push("lz_idx2", 8,  6'b000100, 7'h6D, 1'b1, 1'b0);
        push("lz_idx3", 12, 6'b001000, 7'h3F, 1'b0, 1'b0);
        push("lz_idx4", 16, 6'b010000, 7'h6F, 1'b0, 1'b0);
        push("lz_idx5", 20, 6'b100000, 7'h00, 1'b0, 1'b0);
        forever begin
            #1;
            while (sb.size() != 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                    failures++;
                    $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                             e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                end
            end
            if (sb.size() == 0) break;
            n++;
            if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
            @(negedge clock);
        end
    endtask

    task automatic test_digit_err();
        exp_t e;
        int n;
        apply_reset();
        for (int step = 0; step < 6; step++) begin
            case (step)
                0: begin
                    do_load(2'd1, 4'd2, 4'd6, 4'd4, 4'd5, 4'd6);
                    push("err_m1_idx0", 1,  6'b000001, 7'h7D, 1'b0, 1'b1);
                    push("err_m1_idx3", 12, 6'b001000, 7'h40, 1'b0, 1'b1);
                end
                1: begin
                    do_load(2'd1, 4'd0, 4'd2, 4'd0, 4'd3, 4'd0);
                    push("err_clear_idx3", 13, 6'b001000, 7'h5B, 1'b0, 1'b0);
                    push("err_hold_idx3",  15, 6'b001000, 7'h5B, 1'b0, 1'b0);
                end
                2: begin
                    do_load(2'd2, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0);
                    push("err_h25_idx4", 16, 6'b010000, 7'h40, 1'b0, 1'b1);
                    push("err_h25_idx5", 20, 6'b100000, 7'h5B, 1'b0, 1'b1);
                end
                3: begin
                    do_load(2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
                    push("err_h3x_idx5", 21, 6'b100000, 7'h40, 1'b0, 1'b1);
                end
                4: begin
                    do_load(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
                    push("max_idx5", 22, 6'b100000, 7'h5B, 1'b0, 1'b0);
                    push("max_idx0", 24, 6'b000001, 7'h6F, 1'b0, 1'b0);
                    push("max_idx1", 28, 6'b000010, 7'h6D, 1'b0, 1'b0);
                end
                default: begin
                    do_load(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd10);
                    push("err_s0_idx1", 29, 6'b000010, 7'h6D, 1'b0, 1'b1);
                    push("err_s0_idx4", 40, 6'b010000, 7'h4F, 1'b1, 1'b1);
                    push("err_s0_idx0", 48, 6'b000001, 7'h40, 1'b0, 1'b1);
                end
            endcase
            n = 0;
            forever begin
                #1;
                while (sb.size() != 0 && sb[0].at <= t) begin
                    e = sb.pop_front();
                    checks++;
                    if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                        failures++;
                        $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                                 e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                    end
                end
                if (sb.size() == 0) break;
                n++;
                if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_alarm();
        exp_t e;
        int n;
        apply_reset();
        bus.Alarm = 1'b1;
        for (int step = 0; step < 2; step++) begin
            if (step == 0) begin
                push("alm_t0",  0,  6'b000001, 7'h3F, 1'b0, 1'b0);
                push("alm_t9",  9,  6'b000100, 7'h3F, 1'b1, 1'b0);
                push("alm_t10", 10, 6'b000000, 7'h00, 1'b0, 1'b0);
                push("alm_t17", 17, 6'b000000, 7'h00, 1'b0, 1'b0);
                push("alm_t19", 19, 6'b000000, 7'h00, 1'b0, 1'b0);
                push("alm_t20", 20, 6'b100000, 7'h00, 1'b0, 1'b0);
                push("alm_t24", 24, 6'b000001, 7'h3F, 1'b0, 1'b0);
                push("alm_t29", 29, 6'b000010, 7'h3F, 1'b0, 1'b0);
            end else begin
                bus.Alarm = 1'b0;
                push("noalm_t30", 30, 6'b000010, 7'h3F, 1'b0, 1'b0);
                push("noalm_t34", 34, 6'b000100, 7'h3F, 1'b0, 1'b0);
                push("noalm_t39", 39, 6'b001000, 7'h3F, 1'b0, 1'b0);
            end
            n = 0;
            forever begin
                #1;
                while (sb.size() != 0 && sb[0].at <= t) begin
                    e = sb.pop_front();
                    checks++;
                    if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                        failures++;
                        $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                                 e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                    end
                end
                if (sb.size() == 0) break;
                n++;
                if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
                @(negedge clock);
            end
        end
    endtask

    // Cycle-by-cycle sweep over 12:34:56; expected index and blink phase derived from elapsed edges
    task automatic test_colon_sweep();
        exp_t e;
        int n = 0;
        logic [6:0] tbl [6];
        logic [5:0] one_hot;
        int unsigned idx;
        logic phase;
        tbl = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        apply_reset();
        do_load(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int unsigned tt = 1; tt <= 72; tt++) begin
            idx = (tt / 4) % 6;
            phase = (((tt / 10) % 2) == 0);
            one_hot = 6'b000001;
            one_hot = one_hot << idx;
            push("sweep", tt, one_hot, tbl[idx], phase && (idx == 2 || idx == 4), 1'b0);
        end
        forever begin
            #1;
            while (sb.size() != 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                    failures++;
                    $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                             e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                end
            end
            if (sb.size() == 0) break;
            n++;
            if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        int n;
        apply_reset();
        do_load(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        for (int step = 0; step < 3; step++) begin
            case (step)
                0: push("mid_idx3", 13, 6'b001000, 7'h4F, 1'b0, 1'b0);
                1: begin
                    bus.load = 1'b1;
                    bus.M_in1 = 4'd7;
                    reset = 1'b1;
                    push("mid_async", 0, 6'b000001, 7'h3F, 1'b0, 1'b0);
                end
                default: begin
                    @(negedge clock);
                    bus.load = 1'b0;
                    reset = 1'b0;
                    push("mid_restart_t0", 0, 6'b000001, 7'h3F, 1'b0, 1'b0);
                    push("mid_restart_t3", 3, 6'b000001, 7'h3F, 1'b0, 1'b0);
                    push("mid_restart_t4", 4, 6'b000010, 7'h3F, 1'b0, 1'b0);
                    push("mid_restart_t12", 12, 6'b001000, 7'h3F, 1'b0, 1'b0);
                end
            endcase
            n = 0;
            forever begin
                #1;
                while (sb.size() != 0 && sb[0].at <= t) begin
                    e = sb.pop_front();
                    checks++;
                    if ({bus.an, bus.seg, bus.dp, bus.digit_err} !== {e.an, e.seg, e.dp, e.err} || e.at != t) begin
                        failures++;
                        $display("FAIL %s t=%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b at t=%0d",
                                 e.name, t, bus.an, bus.seg, bus.dp, bus.digit_err, e.an, e.seg, e.dp, e.err, e.at);
                    end
                end
                if (sb.size() == 0) break;
                n++;
                if (n > 400) begin checks++; failures++; $display("FAIL %s timeout t=%0d", sb[0].name, t); sb.delete(); break; end
                @(negedge clock);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.load = 1'b0;
        bus.Alarm = 1'b0;
        bus.H_in1 = '0; bus.H_in0 = '0; bus.M_in1 = '0;
        bus.M_in0 = '0; bus.S_in1 = '0; bus.S_in0 = '0;
        test_reset();
        test_scan();
        test_leading_blank();
        test_digit_err();
        test_alarm();
        test_colon_sweep();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
